// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared constants for the fetch/load-store memory arbiter: FSM encoding,
// requester IDs and parameter limits.
package imem_dmem_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int NUM_LANES       = 4;
    localparam int MAX_MEM_LATENCY = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last winner
// so the other requester takes the next tie.
module rr_arb2
    import imem_dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_grant;

    always_comb begin
        gnt_valid = |req;
        gnt_id    = REQ_I;
        if (req[REQ_I] && req[REQ_D])
            gnt_id = (last_grant == REQ_D) ? REQ_I : REQ_D;
        else if (req[REQ_D])
            gnt_id = REQ_D;
    end

    // Reset to DATA so fetch wins the first tie.
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= REQ_D;
        else if (en && gnt_valid)
            last_grant <= gnt_id;
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported, fixed-latency word memory between the fetch port
// and the load/store port of the core; all outputs are registered.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 i_ack,
    output logic [DATA_W-1:0]    i_rdata,
    output logic                 i_err,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [NUM_LANES-1:0] d_wmask,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [DATA_W-1:0]    d_wdata,
    output logic                 d_ack,
    output logic [DATA_W-1:0]    d_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [NUM_LANES-1:0] mem_wmask,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 busy
);

    localparam bit LAT_OK = (MEM_LATENCY >= 1) && (MEM_LATENCY <= MAX_MEM_LATENCY)
                            && ((MEM_LATENCY - 1) < (1 << CNT_W));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    if (!LAT_OK) begin : g_bad_latency
        $error("imem_dmem_arbiter: MEM_LATENCY out of range for CNT_W");
    end

    state_t             state, state_nxt;
    logic               cur_id;
    logic               cur_we;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-3:0]  addr_q;
    logic               gnt_valid;
    logic               gnt_id;
    logic               fetch_misaligned;
    logic               unused_addr_lsb;

    // Word addresses only; the low byte-offset bits never reach memory.
    assign mem_addr        = {addr_q, 2'b00};
    assign unused_addr_lsb = ^d_addr[1:0];

    assign fetch_misaligned = (gnt_id == REQ_I) && (i_addr[1:0] != 2'b00);

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({d_req, i_req}),
        .en        (state == ST_IDLE),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (gnt_valid) state_nxt = fetch_misaligned ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (cnt == CNT_LAST) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cur_id    <= REQ_I;
            cur_we    <= 1'b0;
            cnt       <= '0;
            addr_q    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != ST_IDLE);
            // Strobes and responses are single-cycle; only the grant/WAIT paths raise them.
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= '0;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        cur_id <= gnt_id;
                        if (gnt_id == REQ_D) begin
                            cur_we    <= d_we;
                            addr_q    <= d_addr[ADDR_W-1:2];
                            mem_en    <= 1'b1;
                            mem_we    <= d_we;
                            mem_wmask <= d_we ? d_wmask : '0;
                            mem_wdata <= d_wdata;
                        end else begin
                            cur_we    <= 1'b0;
                            addr_q    <= i_addr[ADDR_W-1:2];
                            mem_wdata <= '0;
                            if (fetch_misaligned) begin
                                i_ack <= 1'b1;
                                i_err <= 1'b1;
                            end else begin
                                mem_en <= 1'b1;
                            end
                        end
                    end
                end
                ST_ISSUE: cnt <= '0;
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        if (cur_id == REQ_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= cur_we ? '0 : mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench: one arbiter at MEM_LATENCY=1 and one at 4, each with a
// small behavioural memory, checked against hand-computed values.
module tb_imem_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: MEM_LATENCY=1
    logic        a_i_req, a_i_ack, a_i_err, a_d_req, a_d_we, a_d_ack;
    logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [3:0]  a_d_wmask, a_mem_wmask;
    logic        a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    // Instance B: MEM_LATENCY=4
    logic        b_i_req, b_i_ack, b_i_err, b_d_req, b_d_we, b_d_ack;
    logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [3:0]  b_d_wmask, b_mem_wmask;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    imem_dmem_arbiter #(.MEM_LATENCY(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .i_req(a_i_req), .i_addr(a_i_addr), .i_ack(a_i_ack), .i_rdata(a_i_rdata), .i_err(a_i_err),
        .d_req(a_d_req), .d_we(a_d_we), .d_wmask(a_d_wmask), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_ack(a_d_ack), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_wmask(a_mem_wmask), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    imem_dmem_arbiter #(.MEM_LATENCY(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata), .i_err(b_i_err),
        .d_req(b_d_req), .d_we(b_d_we), .d_wmask(b_d_wmask), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_wmask(b_mem_wmask), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory models
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic [31:0] a_rd;
    logic [31:0] b_pipe [0:3];

    assign a_mem_rdata = a_rd;
    assign b_mem_rdata = b_pipe[3];

    always @(posedge clk) begin
        if (a_mem_en) begin
            a_rd <= mem_a[a_mem_addr[7:2]];
            if (a_mem_we)
                for (int k = 0; k < 4; k++)
                    if (a_mem_wmask[k]) mem_a[a_mem_addr[7:2]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
        end
    end

    always @(posedge clk) begin
        if (b_mem_en) b_pipe[0] <= mem_b[b_mem_addr[7:2]];
        for (int k = 1; k < 4; k++) b_pipe[k] <= b_pipe[k-1];
    end

    // Monitors on instance A
    int men_a = 0;
    int both_ack = 0;
    int men_a_cyc [$];
    always @(negedge clk) begin
        if (a_mem_en) begin
            men_a <= men_a + 1;
            men_a_cyc.push_back(cyc);
        end
        if (a_i_ack && a_d_ack) both_ack <= both_ack + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the selected ack; latency is edges after the request cycle.
    logic [31:0] seen_addr;
    logic        seen_we;
    logic [3:0]  seen_mask;
    int          seen_en;

    task automatic wait_ack(input bit inst_b, input bit is_d, output int lat,
                            output logic [31:0] rd, output logic err);
        logic ack;
        lat = -1; rd = '0; err = 1'b0;
        seen_en = 0; seen_we = 1'b0; seen_mask = '0; seen_addr = '0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (inst_b ? b_mem_en : a_mem_en) begin
                seen_en++;
                seen_we   = inst_b ? b_mem_we : a_mem_we;
                seen_mask = inst_b ? b_mem_wmask : a_mem_wmask;
                seen_addr = inst_b ? b_mem_addr : a_mem_addr;
            end
            ack = inst_b ? (is_d ? b_d_ack : b_i_ack) : (is_d ? a_d_ack : a_i_ack);
            if (ack) begin
                lat = c;
                rd  = inst_b ? (is_d ? b_d_rdata : b_i_rdata) : (is_d ? a_d_rdata : a_i_rdata);
                err = inst_b ? b_i_err : a_i_err;
                break;
            end
        end
    endtask

    int          lat;
    logic [31:0] rd;
    logic        err;
    logic [3:0]  order;
    int          nack;
    int          men_before;
    int          ack_seen;

    initial begin
        for (int k = 0; k < 64; k++) begin mem_a[k] = '0; mem_b[k] = '0; end
        mem_a[0] = 32'h00500113;
        mem_a[1] = 32'h11111111;
        mem_b[7] = 32'hCAFEF00D;
        for (int k = 0; k < 4; k++) b_pipe[k] = '0;
        a_rd = '0;
        {a_i_req, a_d_req, a_d_we, b_i_req, b_d_req, b_d_we} = '0;
        {a_i_addr, a_d_addr, a_d_wdata, b_i_addr, b_d_addr, b_d_wdata} = '0;
        a_d_wmask = '0; b_d_wmask = '0;

        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("reset_outs", {28'd0, a_busy, a_i_ack, a_d_ack, a_mem_en}, 32'd0);
        chk("reset_b_outs", {29'd0, b_busy, b_mem_en, b_d_ack}, 32'd0);

        // Aligned fetch at address 0
        a_i_addr = 32'h0; a_i_req = 1'b1;
        wait_ack(1'b0, 1'b0, lat, rd, err);
        a_i_req = 1'b0;
        chk("fetch_lat", lat, 3);
        chk("fetch_rdata", rd, 32'h00500113);
        chk("fetch_err", {31'd0, err}, 0);
        chk("fetch_mem_en_cnt", seen_en, 1);
        chk("fetch_mem_we", {31'd0, seen_we}, 0);
        tick();
        chk("fetch_idle", {30'd0, a_busy, a_i_ack}, 0);

        // Partial store then load back
        a_d_addr = 32'h10; a_d_we = 1'b1; a_d_wmask = 4'b0011; a_d_wdata = 32'hDEADBEEF; a_d_req = 1'b1;
        wait_ack(1'b0, 1'b1, lat, rd, err);
        a_d_req = 1'b0;
        chk("store_lat", lat, 3);
        chk("store_rdata", rd, 0);
        chk("store_mem", {seen_we, seen_mask, seen_addr[26:0]}, {1'b1, 4'b0011, 27'h10});
        tick();
        a_d_we = 1'b0; a_d_wmask = 4'b1111; a_d_req = 1'b1;
        wait_ack(1'b0, 1'b1, lat, rd, err);
        a_d_req = 1'b0;
        chk("load_rdata", rd, 32'h0000BEEF);
        chk("load_wmask", {27'd0, seen_we, seen_mask}, 0);
        tick();

        // Both requesters held: round-robin I, D, I, D
        reset = 1'b1; tick(); reset = 1'b0;
        men_a_cyc.delete();
        a_i_addr = 32'h4; a_d_addr = 32'h10; a_d_we = 1'b0;
        a_i_req = 1'b1; a_d_req = 1'b1;
        nack = 0; order = '0;
        for (int c = 0; c < 60 && nack < 4; c++) begin
            tick();
            if (a_i_ack) begin order[nack] = 1'b0; nack++; end
            if (a_d_ack) begin order[nack] = 1'b1; nack++; end
        end
        a_i_req = 1'b0; a_d_req = 1'b0;
        chk("rr_acks", nack, 4);
        chk("rr_order", {28'd0, order}, {28'd0, 4'b1010});
        chk("rr_mem_en_cnt", men_a_cyc.size(), 4);
        if (men_a_cyc.size() == 4)
            for (int k = 1; k < 4; k++) chk("rr_spacing", men_a_cyc[k] - men_a_cyc[k-1], 4);
        tick(); tick();
        chk("rr_idle", {31'd0, a_busy}, 0);

        // Misaligned fetch: immediate error ack, no memory access
        men_before = men_a;
        a_i_addr = 32'h6; a_i_req = 1'b1;
        wait_ack(1'b0, 1'b0, lat, rd, err);
        a_i_req = 1'b0;
        chk("misal_lat", lat, 1);
        chk("misal_err", {31'd0, err}, 1);
        chk("misal_rdata", rd, 0);
        tick(); tick();
        chk("misal_no_mem", men_a - men_before, 0);
        chk("misal_idle", {31'd0, a_busy}, 0);

        // MEM_LATENCY=4 load with low address bits set
        b_d_addr = 32'h1F; b_d_we = 1'b0; b_d_wmask = 4'b1111; b_d_req = 1'b1;
        wait_ack(1'b1, 1'b1, lat, rd, err);
        b_d_req = 1'b0;
        chk("lat4_lat", lat, 6);
        chk("lat4_rdata", rd, 32'hCAFEF00D);
        chk("lat4_mem_addr", seen_addr, 32'h1C);
        tick();

        // Reset during the WAIT cycle of a fetch
        a_i_addr = 32'h0; a_i_req = 1'b1;
        tick();
        chk("rst_issue", {31'd0, a_mem_en}, 1);
        tick();
        chk("rst_wait_busy", {31'd0, a_busy}, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0; a_i_req = 1'b0;
        chk("rst_outs", {29'd0, a_busy, a_i_ack, a_mem_en}, 0);
        ack_seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (a_i_ack) ack_seen++;
        end
        chk("rst_no_ack", ack_seen, 0);
        a_i_addr = 32'h4; a_i_req = 1'b1;
        wait_ack(1'b0, 1'b0, lat, rd, err);
        a_i_req = 1'b0;
        chk("rst_refetch_lat", lat, 3);
        chk("rst_refetch_rdata", rd, 32'h11111111);
        tick();

        chk("ack_exclusive", both_ack, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
